// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned ROWS x COLS active-low keypad with per-key debounce and event FIFO.
// Optional define KEYPAD_RELEASE_EVENT_EN also queues release events and drives key_released.
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 3,
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int KEY_W          = $clog2(ROWS*COLS)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [ROWS-1:0]  row,
  output logic [COLS-1:0]  column,
  output logic [KEY_W-1:0] key,
  output logic             valid_key,
  output logic             key_released,
  input  logic             key_ack,
  output logic             overflow
);
  localparam int NKEYS = ROWS * COLS;
  localparam int KI    = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW    = $clog2(SCAN_DIV - 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNTW  = AW + 1;

  // state  | meaning
  // DRIVE  | column col_idx held low, dwell counting
  // SAMPLE | compare ~row against debounced state of col_idx
  // EMIT   | push pending events, lowest row first
  typedef enum logic [1:0] {S_DRIVE, S_SAMPLE, S_EMIT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   col_idx, col_nxt;
  logic [DW-1:0]   dwell, dwell_nxt;
  logic [ROWS-1:0] pending, pend_rest;
  logic [RW-1:0]   low_row;
  logic [KI-1:0]   col_base;
  logic [NKEYS-1:0] db;
  logic [3:0]      cnt [NKEYS];
  logic            push, push_ok, pop, empty, full;
  logic [KEY_W-1:0] push_code;
  logic [KEY_W-1:0] fifo_key [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;

  assign pend_rest = pending & (pending - ROWS'(1));
  assign col_base  = KI'(int'(col_idx) * ROWS);
  assign push_code = KEY_W'(int'(col_idx) * ROWS + int'(low_row));

  always_comb begin
    low_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (pending[r]) low_row = RW'(r);
    end
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    dwell_nxt = dwell;
    push      = 1'b0;
    case (state)
      S_DRIVE: begin
        if (dwell == DW'(SCAN_DIV - 2)) begin
          state_nxt = S_SAMPLE;
          dwell_nxt = '0;
        end else begin
          dwell_nxt = dwell + DW'(1);
        end
      end
      S_SAMPLE: state_nxt = S_EMIT;
      S_EMIT: begin
        push = |pending;
        // leave in the same cycle as the last push so EMIT never exceeds ROWS cycles
        if (pend_rest == '0) begin
          state_nxt = S_DRIVE;
          col_nxt   = (col_idx == CW'(COLS - 1)) ? '0 : col_idx + CW'(1);
        end
      end
      default: state_nxt = S_DRIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state   <= S_DRIVE;
      col_idx <= '0;
      dwell   <= '0;
      column  <= '1;
    end else begin
      state   <= state_nxt;
      col_idx <= col_nxt;
      dwell   <= dwell_nxt;
      column  <= ~(COLS'(1) << col_nxt);
    end
  end

`ifdef KEYPAD_RELEASE_EVENT_EN
  logic [ROWS-1:0] pend_rel;
  logic            fifo_rel [FIFO_DEPTH];
  logic            push_rel;
  assign push_rel = pend_rel[low_row];
`endif

  always_ff @(posedge clk) begin
    if (!clear) begin
      db      <= '0;
      pending <= '0;
      for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
      pend_rel <= '0;
`endif
    end else if (state == S_SAMPLE) begin
      for (int r = 0; r < ROWS; r++) begin
        if (~row[r] == db[col_base + KI'(r)]) begin
          cnt[col_base + KI'(r)] <= '0;
        end else if (cnt[col_base + KI'(r)] == 4'(DEBOUNCE_SCANS - 1)) begin
          db[col_base + KI'(r)]  <= ~row[r];
          cnt[col_base + KI'(r)] <= '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
          pending[r]  <= 1'b1;
          pend_rel[r] <= row[r];
`else
          if (!row[r]) pending[r] <= 1'b1;
`endif
        end else begin
          cnt[col_base + KI'(r)] <= cnt[col_base + KI'(r)] + 4'd1;
        end
      end
    end else if (state == S_EMIT) begin
      pending <= pend_rest;
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CNTW'(FIFO_DEPTH));
  assign pop     = key_ack & ~empty;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (clear && push_ok) begin
      fifo_key[wr_ptr] <= push_code;
`ifdef KEYPAD_RELEASE_EVENT_EN
      fifo_rel[wr_ptr] <= push_rel;
`endif
    end
  end

  // head outputs are registered, so they trail the FIFO pointers by one cycle
  always_ff @(posedge clk) begin
    if (!clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      key       <= '0;
      valid_key <= 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
      key_released <= 1'b0;
`endif
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop) count <= count + CNTW'(1);
      else if (pop && !push_ok) count <= count - CNTW'(1);
      if (push && !push_ok) overflow <= 1'b1;
      valid_key <= ~empty;
      if (!empty) begin
        key <= fifo_key[rd_ptr];
`ifdef KEYPAD_RELEASE_EVENT_EN
        key_released <= fifo_rel[rd_ptr];
`endif
      end
    end
  end

`ifndef KEYPAD_RELEASE_EVENT_EN
  assign key_released = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of keypad_scanner with a physical 4x3 keypad model.
// Optional define KEYPAD_RELEASE_EVENT_EN switches the release-event expectations.
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] row;
  logic [2:0] column;
  logic [3:0] key;
  logic       valid_key, key_released, key_ack, overflow;
  logic [11:0] pressed;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ovf_codes [4] = '{0, 6, 10, 3};

  keypad_scanner #(.ROWS(4), .COLS(3), .SCAN_DIV(8), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .clear(clear), .row(row), .column(column), .key(key),
    .valid_key(valid_key), .key_released(key_released), .key_ack(key_ack), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // a closed switch pulls its row low only while its column is driven low
  always_comb begin
    row = '1;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++)
        if (!column[c] && pressed[c*4 + r]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [2:0] drv(input int c);
    logic [2:0] one;
    one = 3'b001;
    return ~(one << c);
  endfunction

  task automatic wait_col(input int c, input bit on);
    int n;
    n = 0;
    while (((column == drv(c)) != on) && n < 200) begin
      cyc(1);
      n++;
    end
    if (n >= 200) chk("wait_col_timeout", n, 0);
  endtask

  task automatic pass_col(input int c);
    wait_col(c, 1'b1);
    wait_col(c, 1'b0);
  endtask

  task automatic do_ack();
    key_ack = 1'b1;
    cyc(1);
    key_ack = 1'b0;
    cyc(1);
  endtask

  task automatic press_key(input int k);
    wait_col(k / 4, 1'b0);
    pressed[k] = 1'b1;
    repeat (3) pass_col(k / 4);
    cyc(2);
  endtask

  task automatic release_key(input int k);
    wait_col(k / 4, 1'b0);
    pressed[k] = 1'b0;
    repeat (3) pass_col(k / 4);
    cyc(2);
`ifdef KEYPAD_RELEASE_EVENT_EN
    chk("rel_valid", valid_key, 1);
    chk("rel_key", key, k);
    chk("rel_flag", key_released, 1);
    do_ack();
`endif
    chk("rel_quiet", valid_key, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0;
    key_ack = 1'b0;
    pressed = '0;
    cyc(3);
    chk("rst_column", column, 3'b111);
    chk("rst_valid", valid_key, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_key", key, 0);
    chk("rst_released", key_released, 0);
    clear = 1'b1;
    cyc(1);
    chk("col0_first", column, 3'b110);
    cyc(6);
    chk("col0_dwell", column, 3'b110);
    wait_col(1, 1'b1);
    chk("col1_next", column, 3'b101);

    // single press on row1/col2, visible only while col2 is driven
    wait_col(2, 1'b0);
    pressed[9] = 1'b1;
    repeat (2) pass_col(2);
    cyc(3);
    chk("press_2scans", valid_key, 0);
    pass_col(2);
    cyc(2);
    chk("press_valid", valid_key, 1);
    chk("press_key", key, 9);
    chk("press_rel", key_released, 0);
    do_ack();
    chk("press_acked", valid_key, 0);
    repeat (4) pass_col(2);
    cyc(2);
    chk("press_norepeat", valid_key, 0);
    release_key(9);

    // bounce: 2 pressed, 1 released, 3 pressed samples
    wait_col(0, 1'b0);
    pressed[1] = 1'b1;
    repeat (2) pass_col(0);
    pressed[1] = 1'b0;
    pass_col(0);
    pressed[1] = 1'b1;
    repeat (2) pass_col(0);
    cyc(3);
    chk("bounce_early", valid_key, 0);
    pass_col(0);
    cyc(2);
    chk("bounce_valid", valid_key, 1);
    chk("bounce_key", key, 1);
    do_ack();
    chk("bounce_single", valid_key, 0);
    release_key(1);

    // two keys in col1 together
    wait_col(1, 1'b0);
    pressed[4] = 1'b1;
    pressed[7] = 1'b1;
    repeat (3) pass_col(1);
    cyc(2);
    chk("multi_first", key, 4);
    chk("multi_valid", valid_key, 1);
    do_ack();
    chk("multi_second", key, 7);
    chk("multi_valid2", valid_key, 1);
    do_ack();
    chk("multi_empty", valid_key, 0);
    release_key(4);
    release_key(7);

    // five presses into a four-deep FIFO
    press_key(0);
    press_key(6);
    press_key(10);
    press_key(3);
    chk("ovf_at_4", overflow, 0);
    press_key(11);
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", valid_key, 1);
      chk("drain_key", key, ovf_codes[i]);
      do_ack();
    end
    chk("drain_empty", valid_key, 0);
    chk("ovf_sticky", overflow, 1);
    pressed = '0;
    clear = 1'b0;
    cyc(2);
    chk("clr_column", column, 3'b111);
    clear = 1'b1;
    cyc(1);
    chk("clr_ovf", overflow, 0);
    chk("clr_valid", valid_key, 0);
    chk("clr_col0", column, 3'b110);

    // ack on an empty FIFO must not disturb later events
    key_ack = 1'b1;
    cyc(2);
    key_ack = 1'b0;
    cyc(1);
    chk("ack_empty", valid_key, 0);

    press_key(5);
    chk("k5_valid", valid_key, 1);
    chk("k5_key", key, 5);
    chk("k5_rel", key_released, 0);
    do_ack();
    chk("k5_empty", valid_key, 0);
    release_key(5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
